// File: rtl/hsi_config_sequencer.sv
// Configuration sequencer for the HSI detector: streams register writes into the
// matrix/sR/sRs stores, tracks completeness and supervises one output frame per start.
module hsi_config_sequencer #(
  parameter int unsigned NUM_BANDS      = 16,
  parameter int unsigned CFG_DATA_WIDTH = 32,
  parameter int unsigned MAT_ADDR_WIDTH = 8,
  parameter int unsigned SR_ADDR_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CFG_WE,
  input  logic [3:0]                CFG_ADDR,
  input  logic [CFG_DATA_WIDTH-1:0] CFG_WDATA,
  output logic                      MAT_WE,
  output logic [MAT_ADDR_WIDTH-1:0] MAT_ADDR,
  output logic [CFG_DATA_WIDTH-1:0] MAT_WDATA,
  output logic                      SR_WE,
  output logic [SR_ADDR_WIDTH-1:0]  SR_ADDR,
  output logic [CFG_DATA_WIDTH-1:0] SR_WDATA,
  output logic [CFG_DATA_WIDTH-1:0] SRS_DATA,
  output logic                      DEBUG,
  output logic                      DP_EN,
  input  logic                      OUT_TVALID,
  input  logic                      OUT_TREADY,
  input  logic                      OUT_TLAST,
  output logic                      FRAME_DONE,
  output logic                      CFG_ERR,
  output logic [31:0]               STATUS
);

  localparam int unsigned MAT_CNT_W = MAT_ADDR_WIDTH + 1;
  localparam int unsigned SR_CNT_W  = SR_ADDR_WIDTH + 1;
  localparam logic [MAT_CNT_W-1:0] MAT_DEPTH = MAT_CNT_W'(NUM_BANDS * NUM_BANDS);
  localparam logic [MAT_CNT_W-1:0] MAT_LAST  = MAT_CNT_W'(NUM_BANDS * NUM_BANDS - 1);
  localparam logic [SR_CNT_W-1:0]  SR_DEPTH  = SR_CNT_W'(NUM_BANDS);
  localparam logic [SR_CNT_W-1:0]  SR_LAST   = SR_CNT_W'(NUM_BANDS - 1);
  localparam logic [25:0]          BEAT_MAX  = '1;

  typedef enum logic [1:0] {
    CONFIG = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [MAT_CNT_W-1:0]      mat_cnt, mat_cnt_nxt;
  logic [SR_CNT_W-1:0]       sr_cnt, sr_cnt_nxt;
  logic                      mat_loaded, mat_loaded_nxt;
  logic                      sr_loaded, sr_loaded_nxt;
  logic                      srs_loaded, srs_loaded_nxt;
  logic                      cfg_err_nxt;
  logic [25:0]               beat_cnt, beat_cnt_nxt;

  logic                      mat_we_nxt, sr_we_nxt, debug_nxt, dp_en_nxt, frame_done_nxt;
  logic [MAT_ADDR_WIDTH-1:0] mat_addr_nxt;
  logic [SR_ADDR_WIDTH-1:0]  sr_addr_nxt;
  logic [CFG_DATA_WIDTH-1:0] mat_wdata_nxt, sr_wdata_nxt, srs_data_nxt;
  logic [31:0]               status_nxt;

  logic wr_mat, wr_sr, wr_srs, wr_ctl, clear, start, handshake;

  always_comb begin
    wr_mat    = CFG_WE && (CFG_ADDR == 4'h0);
    wr_sr     = CFG_WE && (CFG_ADDR == 4'h4);
    wr_srs    = CFG_WE && (CFG_ADDR == 4'h8);
    wr_ctl    = CFG_WE && (CFG_ADDR == 4'hC);
    clear     = wr_ctl && CFG_WDATA[1];
    start     = wr_ctl && CFG_WDATA[2] && !CFG_WDATA[1];
    handshake = OUT_TVALID && OUT_TREADY;

    state_nxt      = state;
    mat_cnt_nxt    = mat_cnt;
    sr_cnt_nxt     = sr_cnt;
    mat_loaded_nxt = mat_loaded;
    sr_loaded_nxt  = sr_loaded;
    srs_loaded_nxt = srs_loaded;
    cfg_err_nxt    = CFG_ERR;
    beat_cnt_nxt   = beat_cnt;
    mat_we_nxt     = 1'b0;
    mat_addr_nxt   = MAT_ADDR;
    mat_wdata_nxt  = MAT_WDATA;
    sr_we_nxt      = 1'b0;
    sr_addr_nxt    = SR_ADDR;
    sr_wdata_nxt   = SR_WDATA;
    srs_data_nxt   = SRS_DATA;
    debug_nxt      = DEBUG;
    frame_done_nxt = 1'b0;

    if (wr_ctl) debug_nxt = CFG_WDATA[0];

    if (state != RUN) begin
      if (wr_mat) begin
        if (mat_cnt < MAT_DEPTH) begin
          mat_we_nxt    = 1'b1;
          mat_addr_nxt  = mat_cnt[MAT_ADDR_WIDTH-1:0];
          mat_wdata_nxt = CFG_WDATA;
          mat_cnt_nxt   = mat_cnt + MAT_CNT_W'(1);
          if (mat_cnt == MAT_LAST) mat_loaded_nxt = 1'b1;
        end else begin
          cfg_err_nxt = 1'b1;
        end
      end
      if (wr_sr) begin
        if (sr_cnt < SR_DEPTH) begin
          sr_we_nxt    = 1'b1;
          sr_addr_nxt  = sr_cnt[SR_ADDR_WIDTH-1:0];
          sr_wdata_nxt = CFG_WDATA;
          sr_cnt_nxt   = sr_cnt + SR_CNT_W'(1);
          if (sr_cnt == SR_LAST) sr_loaded_nxt = 1'b1;
        end else begin
          cfg_err_nxt = 1'b1;
        end
      end
      if (wr_srs) begin
        srs_data_nxt   = CFG_WDATA;
        srs_loaded_nxt = 1'b1;
      end
    end

    case (state)
      CONFIG: begin
        if (start) cfg_err_nxt = 1'b1;
        if (mat_loaded && sr_loaded && srs_loaded) state_nxt = ARMED;
      end
      ARMED: begin
        if (start) begin
          state_nxt    = RUN;
          beat_cnt_nxt = '0;
        end
      end
      RUN: begin
        if (wr_mat || wr_sr || wr_srs) cfg_err_nxt = 1'b1;
        if (handshake) begin
          if (beat_cnt != BEAT_MAX) beat_cnt_nxt = beat_cnt + 26'd1;
          if (OUT_TLAST) begin
            frame_done_nxt = 1'b1;
            state_nxt      = ARMED;
          end
        end
      end
      default: state_nxt = CONFIG;
    endcase

    // Clear overrides everything above, including a same-cycle TLAST (no FRAME_DONE).
    if (clear) begin
      mat_cnt_nxt    = '0;
      sr_cnt_nxt     = '0;
      mat_loaded_nxt = 1'b0;
      sr_loaded_nxt  = 1'b0;
      srs_loaded_nxt = 1'b0;
      cfg_err_nxt    = 1'b0;
      frame_done_nxt = 1'b0;
      state_nxt      = CONFIG;
    end

    dp_en_nxt  = (state_nxt == RUN);
    status_nxt = {cfg_err_nxt, state_nxt, srs_loaded_nxt, sr_loaded_nxt,
                  mat_loaded_nxt, beat_cnt_nxt};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= CONFIG;
      mat_cnt    <= '0;
      sr_cnt     <= '0;
      mat_loaded <= 1'b0;
      sr_loaded  <= 1'b0;
      srs_loaded <= 1'b0;
      beat_cnt   <= '0;
      MAT_WE     <= 1'b0;
      MAT_ADDR   <= '0;
      MAT_WDATA  <= '0;
      SR_WE      <= 1'b0;
      SR_ADDR    <= '0;
      SR_WDATA   <= '0;
      SRS_DATA   <= '0;
      DEBUG      <= 1'b0;
      DP_EN      <= 1'b0;
      FRAME_DONE <= 1'b0;
      CFG_ERR    <= 1'b0;
      STATUS     <= '0;
    end else begin
      state      <= state_nxt;
      mat_cnt    <= mat_cnt_nxt;
      sr_cnt     <= sr_cnt_nxt;
      mat_loaded <= mat_loaded_nxt;
      sr_loaded  <= sr_loaded_nxt;
      srs_loaded <= srs_loaded_nxt;
      beat_cnt   <= beat_cnt_nxt;
      MAT_WE     <= mat_we_nxt;
      MAT_ADDR   <= mat_addr_nxt;
      MAT_WDATA  <= mat_wdata_nxt;
      SR_WE      <= sr_we_nxt;
      SR_ADDR    <= sr_addr_nxt;
      SR_WDATA   <= sr_wdata_nxt;
      SRS_DATA   <= srs_data_nxt;
      DEBUG      <= debug_nxt;
      DP_EN      <= dp_en_nxt;
      FRAME_DONE <= frame_done_nxt;
      CFG_ERR    <= cfg_err_nxt;
      STATUS     <= status_nxt;
    end
  end

endmodule

// File: tb/tb_hsi_config_sequencer.sv
// Self-checking bench for hsi_config_sequencer: randomized writes and output-stream
// traffic compared against a count/flag level reference model of the sequencer.
module tb_hsi_config_sequencer;

  localparam int NB = 16;
  localparam int MD = NB * NB;
  localparam int BEAT_MAX = (1 << 26) - 1;

  logic        CLK = 1'b0;
  logic        RESET, CFG_WE, OUT_TVALID, OUT_TREADY, OUT_TLAST;
  logic [3:0]  CFG_ADDR;
  logic [31:0] CFG_WDATA;
  logic        MAT_WE, SR_WE, DEBUG, DP_EN, FRAME_DONE, CFG_ERR;
  logic [7:0]  MAT_ADDR;
  logic [3:0]  SR_ADDR;
  logic [31:0] MAT_WDATA, SR_WDATA, SRS_DATA, STATUS;

  hsi_config_sequencer #(
    .NUM_BANDS(16), .CFG_DATA_WIDTH(32), .MAT_ADDR_WIDTH(8), .SR_ADDR_WIDTH(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_WDATA(CFG_WDATA),
    .MAT_WE(MAT_WE), .MAT_ADDR(MAT_ADDR), .MAT_WDATA(MAT_WDATA),
    .SR_WE(SR_WE), .SR_ADDR(SR_ADDR), .SR_WDATA(SR_WDATA), .SRS_DATA(SRS_DATA),
    .DEBUG(DEBUG), .DP_EN(DP_EN), .OUT_TVALID(OUT_TVALID), .OUT_TREADY(OUT_TREADY),
    .OUT_TLAST(OUT_TLAST), .FRAME_DONE(FRAME_DONE), .CFG_ERR(CFG_ERR), .STATUS(STATUS)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state as 0/1/2, write counts, loaded derived from counts.
  int          m_state, m_mat, m_sr, m_beats, e_mat_addr, e_sr_addr;
  logic        m_srs_ld, m_err, m_dbg, m_fd, e_mat_we, e_sr_we;
  logic [31:0] m_srs, e_mat_data, e_sr_data;

  function automatic logic [31:0] exp_status();
    logic [1:0]  st = m_state[1:0];
    logic [25:0] bc = m_beats[25:0];
    return {m_err, st, m_srs_ld, logic'(m_sr == NB), logic'(m_mat == MD), bc};
  endfunction

  task automatic model_update();
    logic wr_mat, wr_sr, wr_srs, wr_ctl, hs, st, ready;
    e_mat_we = 1'b0;
    e_sr_we  = 1'b0;
    m_fd     = 1'b0;
    if (RESET) begin
      m_state = 0; m_mat = 0; m_sr = 0; m_beats = 0;
      m_srs_ld = 1'b0; m_err = 1'b0; m_dbg = 1'b0; m_srs = '0;
      return;
    end
    wr_mat = CFG_WE && CFG_ADDR == 4'h0;
    wr_sr  = CFG_WE && CFG_ADDR == 4'h4;
    wr_srs = CFG_WE && CFG_ADDR == 4'h8;
    wr_ctl = CFG_WE && CFG_ADDR == 4'hC;
    hs     = OUT_TVALID && OUT_TREADY;
    st     = wr_ctl && CFG_WDATA[2];
    ready  = (m_mat == MD) && (m_sr == NB) && m_srs_ld;
    if (wr_ctl) m_dbg = CFG_WDATA[0];
    if (wr_ctl && CFG_WDATA[1]) begin
      m_mat = 0; m_sr = 0; m_srs_ld = 1'b0; m_err = 1'b0; m_state = 0;
      return;
    end
    if (m_state == 2) begin
      if (wr_mat || wr_sr || wr_srs) m_err = 1'b1;
      if (hs) begin
        if (m_beats < BEAT_MAX) m_beats++;
        if (OUT_TLAST) begin m_fd = 1'b1; m_state = 1; end
      end
    end else begin
      if (wr_mat) begin
        if (m_mat < MD) begin
          e_mat_we = 1'b1; e_mat_addr = m_mat; e_mat_data = CFG_WDATA; m_mat++;
        end else m_err = 1'b1;
      end
      if (wr_sr) begin
        if (m_sr < NB) begin
          e_sr_we = 1'b1; e_sr_addr = m_sr; e_sr_data = CFG_WDATA; m_sr++;
        end else m_err = 1'b1;
      end
      if (wr_srs) begin m_srs = CFG_WDATA; m_srs_ld = 1'b1; end
      if (m_state == 0) begin
        if (st) m_err = 1'b1;
        if (ready) m_state = 1;
      end else if (st) begin
        m_state = 2; m_beats = 0;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_write(input logic [3:0] a, input logic [31:0] d);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_WDATA = d;
  endtask

  task automatic test_reset();
    RESET = 1'b1; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_WDATA = '0;
    OUT_TVALID = 1'b0; OUT_TREADY = 1'b0; OUT_TLAST = 1'b0;
    step(); step();
    n_checks++;
    if ({MAT_WE, MAT_ADDR, MAT_WDATA, SR_WE, SR_ADDR, SR_WDATA, SRS_DATA,
         DEBUG, DP_EN, FRAME_DONE, CFG_ERR, STATUS} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got status=%h mat_we=%b dp_en=%b expected all zero", STATUS, MAT_WE, DP_EN);
    end
    n_checks++;
    if (STATUS !== exp_status()) begin
      n_errors++; $display("FAIL reset_status: got %h expected %h", STATUS, exp_status());
    end
    RESET = 1'b0;
  endtask

  task automatic test_matrix_load();
    for (int i = 0; i < MD; i++) begin
      drive_write(4'h0, 32'(i));
      step();
      CFG_WE = 1'b0;
      n_checks++;
      if (MAT_WE !== e_mat_we || (e_mat_we && {MAT_ADDR, MAT_WDATA} !== {8'(e_mat_addr), e_mat_data})) begin
        n_errors++;
        $display("FAIL mat_write[%0d]: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                 i, MAT_WE, MAT_ADDR, MAT_WDATA, e_mat_we, e_mat_addr, e_mat_data);
      end
      step();
      n_checks++;
      if (MAT_WE !== e_mat_we) begin
        n_errors++; $display("FAIL mat_idle[%0d]: got we=%b expected %b", i, MAT_WE, e_mat_we);
      end
    end
    n_checks++;
    if (STATUS !== exp_status() || STATUS[26] !== 1'b1 || STATUS[30:29] !== 2'd0) begin
      n_errors++; $display("FAIL mat_loaded: got status=%h expected %h", STATUS, exp_status());
    end
  endtask

  task automatic test_sr_srs();
    for (int i = 0; i < NB; i++) begin
      drive_write(4'h4, $urandom);
      step();
      CFG_WE = 1'b0;
      n_checks++;
      if (SR_WE !== e_sr_we || (e_sr_we && {SR_ADDR, SR_WDATA} !== {4'(e_sr_addr), e_sr_data})) begin
        n_errors++;
        $display("FAIL sr_write[%0d]: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                 i, SR_WE, SR_ADDR, SR_WDATA, e_sr_we, e_sr_addr, e_sr_data);
      end
    end
    drive_write(4'h8, 32'd1573086748);
    step();
    CFG_WE = 1'b0;
    n_checks++;
    if (SRS_DATA !== 32'd1573086748 || SRS_DATA !== m_srs) begin
      n_errors++; $display("FAIL srs_data: got %h expected %h", SRS_DATA, m_srs);
    end
    n_checks++;
    if (STATUS[30:29] !== 2'd0 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL srs_still_config: got status=%h expected %h", STATUS, exp_status());
    end
    step();
    n_checks++;
    if (STATUS[30:29] !== 2'd1 || STATUS !== exp_status() || CFG_ERR !== 1'b0) begin
      n_errors++; $display("FAIL armed: got status=%h err=%b expected %h", STATUS, CFG_ERR, exp_status());
    end
  endtask

  task automatic test_frame();
    int sent = 0, pulses = 0, cyc = 0;
    drive_write(4'hC, 32'h4);
    step();
    CFG_WE = 1'b0;
    n_checks++;
    if (DP_EN !== 1'b1 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL start_dp_en: got dp_en=%b status=%h expected 1 %h", DP_EN, STATUS, exp_status());
    end
    while (sent < 100 && cyc < 3000) begin
      OUT_TVALID = ($urandom_range(0, 3) != 0);
      OUT_TREADY = $urandom_range(0, 1);
      OUT_TLAST  = (sent == 99);
      if (OUT_TVALID && OUT_TREADY) sent++;
      step();
      cyc++;
      if (FRAME_DONE === 1'b1) pulses++;
      n_checks++;
      if (FRAME_DONE !== m_fd || DP_EN !== logic'(m_state == 2) || STATUS !== exp_status()) begin
        n_errors++;
        $display("FAIL frame_cycle[%0d]: got fd=%b dp=%b status=%h expected fd=%b dp=%b status=%h",
                 cyc, FRAME_DONE, DP_EN, STATUS, m_fd, m_state == 2, exp_status());
      end
    end
    OUT_TVALID = 1'b0; OUT_TREADY = 1'b0; OUT_TLAST = 1'b0;
    n_checks++;
    if (sent < 100) begin
      n_errors++; $display("FAIL frame_timeout: got %0d beats expected 100", sent);
    end
    n_checks++;
    if (STATUS[25:0] !== 26'd100 || STATUS[30:29] !== 2'd1 || DP_EN !== 1'b0) begin
      n_errors++; $display("FAIL frame_end: got status=%h dp=%b expected beats=100 state=1 dp=0", STATUS, DP_EN);
    end
    step();
    if (FRAME_DONE === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1) begin
      n_errors++; $display("FAIL frame_done_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_errors();
    logic [31:0] srs_before;
    drive_write(4'h0, 32'hDEAD_BEEF);
    step();
    CFG_WE = 1'b0;
    n_checks++;
    if (MAT_WE !== 1'b0 || CFG_ERR !== 1'b1 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL mat_overflow: got we=%b err=%b status=%h expected 0 1 %h", MAT_WE, CFG_ERR, STATUS, exp_status());
    end
    drive_write(4'hC, 32'h4);
    step();
    drive_write(4'h4, $urandom);
    step();
    CFG_WE = 1'b0;
    n_checks++;
    if (SR_WE !== 1'b0 || CFG_ERR !== 1'b1 || DP_EN !== 1'b1) begin
      n_errors++; $display("FAIL sr_in_run: got we=%b err=%b dp=%b expected 0 1 1", SR_WE, CFG_ERR, DP_EN);
    end
    srs_before = m_srs;
    drive_write(4'h8, 32'h1234_5678);
    OUT_TVALID = 1'b1; OUT_TREADY = 1'b1; OUT_TLAST = 1'b1;
    step();
    CFG_WE = 1'b0; OUT_TVALID = 1'b0; OUT_TREADY = 1'b0; OUT_TLAST = 1'b0;
    n_checks++;
    if (FRAME_DONE !== 1'b1 || SRS_DATA !== srs_before || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL write_with_tlast: got fd=%b srs=%h status=%h expected 1 %h %h",
                           FRAME_DONE, SRS_DATA, STATUS, srs_before, exp_status());
    end
    drive_write(4'hC, 32'h2);
    step();
    CFG_WE = 1'b0;
    n_checks++;
    if (CFG_ERR !== 1'b0 || STATUS[30:26] !== 5'd0 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL clear: got err=%b status=%h expected 0 %h", CFG_ERR, STATUS, exp_status());
    end
    drive_write(4'hC, 32'h4);
    step();
    CFG_WE = 1'b0;
    n_checks++;
    if (CFG_ERR !== 1'b1 || DP_EN !== 1'b0 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL start_in_config: got err=%b dp=%b status=%h expected 1 0 %h", CFG_ERR, DP_EN, STATUS, exp_status());
    end
    drive_write(4'hC, 32'h1);
    step();
    n_checks++;
    if (DEBUG !== 1'b1 || DEBUG !== m_dbg) begin
      n_errors++; $display("FAIL debug_set: got %b expected %b", DEBUG, m_dbg);
    end
    drive_write(4'hC, 32'h6);
    step();
    CFG_WE = 1'b0;
    n_checks++;
    if (DEBUG !== m_dbg || CFG_ERR !== 1'b0 || DP_EN !== 1'b0 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL clear_wins: got dbg=%b err=%b dp=%b status=%h expected %b 0 0 %h",
                           DEBUG, CFG_ERR, DP_EN, STATUS, m_dbg, exp_status());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < MD + NB + 1; i++) begin
      if (i < MD) drive_write(4'h0, $urandom);
      else if (i < MD + NB) drive_write(4'h4, $urandom);
      else drive_write(4'h8, $urandom);
      step();
      n_checks++;
      if (MAT_WE !== e_mat_we || SR_WE !== e_sr_we ||
          (e_mat_we && {MAT_ADDR, MAT_WDATA} !== {8'(e_mat_addr), e_mat_data}) ||
          (e_sr_we && {SR_ADDR, SR_WDATA} !== {4'(e_sr_addr), e_sr_data})) begin
        n_errors++;
        $display("FAIL b2b[%0d]: got mat=%b/%0d/%h sr=%b/%0d/%h expected mat=%b/%0d/%h sr=%b/%0d/%h",
                 i, MAT_WE, MAT_ADDR, MAT_WDATA, SR_WE, SR_ADDR, SR_WDATA,
                 e_mat_we, e_mat_addr, e_mat_data, e_sr_we, e_sr_addr, e_sr_data);
      end
    end
    CFG_WE = 1'b0;
    step();
    n_checks++;
    if (STATUS[30:29] !== 2'd1 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL b2b_armed: got status=%h expected %h", STATUS, exp_status());
    end
  endtask

  task automatic test_clear_in_run();
    drive_write(4'hC, 32'h4);
    step();
    CFG_WE = 1'b0;
    OUT_TVALID = 1'b1; OUT_TREADY = 1'b1; OUT_TLAST = 1'b0;
    for (int i = 0; i < 40; i++) step();
    OUT_TVALID = 1'b0; OUT_TREADY = 1'b0;
    n_checks++;
    if (STATUS[25:0] !== 26'd40 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL run_beats40: got status=%h expected %h", STATUS, exp_status());
    end
    drive_write(4'hC, 32'h2);
    step();
    CFG_WE = 1'b0;
    n_checks++;
    if (DP_EN !== 1'b0 || FRAME_DONE !== 1'b0 || STATUS[30:29] !== 2'd0 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL clear_in_run: got dp=%b fd=%b status=%h expected 0 0 %h", DP_EN, FRAME_DONE, STATUS, exp_status());
    end
    OUT_TVALID = 1'b1; OUT_TREADY = 1'b1; OUT_TLAST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (FRAME_DONE !== m_fd || DP_EN !== 1'b0) begin
        n_errors++; $display("FAIL no_frame_after_clear[%0d]: got fd=%b dp=%b expected %b 0", i, FRAME_DONE, DP_EN, m_fd);
      end
    end
    OUT_TVALID = 1'b0; OUT_TREADY = 1'b0; OUT_TLAST = 1'b0;
    for (int i = 0; i < NB + 1; i++) begin
      drive_write((i < NB) ? 4'h4 : 4'h8, $urandom);
      step();
    end
    CFG_WE = 1'b0;
    step();
    drive_write(4'hC, 32'h4);
    step();
    CFG_WE = 1'b0;
    n_checks++;
    if (CFG_ERR !== 1'b1 || DP_EN !== 1'b0 || STATUS[30:29] !== 2'd0 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL start_partial_cfg: got err=%b dp=%b status=%h expected 1 0 %h", CFG_ERR, DP_EN, STATUS, exp_status());
    end
  endtask

  task automatic test_reset_with_write();
    RESET = 1'b1;
    drive_write(4'h0, 32'hA5A5_A5A5);
    step();
    CFG_WE = 1'b0;
    RESET = 1'b0;
    n_checks++;
    if ({MAT_WE, MAT_ADDR, MAT_WDATA, SR_WE, SR_ADDR, SR_WDATA, SRS_DATA,
         DEBUG, DP_EN, FRAME_DONE, CFG_ERR, STATUS} !== '0 || e_mat_we !== 1'b0) begin
      n_errors++; $display("FAIL reset_with_write: got mat_we=%b status=%h srs=%h expected all zero", MAT_WE, STATUS, SRS_DATA);
    end
    step();
    n_checks++;
    if (MAT_WE !== 1'b0 || STATUS !== exp_status()) begin
      n_errors++; $display("FAIL after_reset: got mat_we=%b status=%h expected 0 %h", MAT_WE, STATUS, exp_status());
    end
  endtask

  initial begin
    test_reset();
    test_matrix_load();
    test_sr_srs();
    test_frame();
    test_errors();
    test_back_to_back();
    test_clear_in_run();
    test_reset_with_write();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
